// File: rtl/bitwise_pkg.sv
// Shared types for the bitwise unit: opcode encoding and the two-state fold FSM.
// Opcodes select f(a,b); in accumulate mode a is the running fold and b the new beat.
package bitwise_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/bitwise_core.sv
// Combinational bitwise operator, WIDTH bits, no state and no handshake.
// Each bit is built from gate primitives and the opcode picks one gate output.
module bitwise_core
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_and;
        logic w_or;
        logic w_xor;
        logic w_nand;
        logic w_nor;
        logic w_xnor;
        logic w_not;
        logic bit_y;

        and  u_and  (w_and,  a[i], b[i]);
        or   u_or   (w_or,   a[i], b[i]);
        xor  u_xor  (w_xor,  a[i], b[i]);
        nand u_nand (w_nand, a[i], b[i]);
        nor  u_nor  (w_nor,  a[i], b[i]);
        xnor u_xnor (w_xnor, a[i], b[i]);
        not  u_not  (w_not,  a[i]);

        always_comb begin
            bit_y = 1'b0;
            case (op)
                OP_AND:   bit_y = w_and;
                OP_OR:    bit_y = w_or;
                OP_XOR:   bit_y = w_xor;
                OP_NAND:  bit_y = w_nand;
                OP_NOR:   bit_y = w_nor;
                OP_XNOR:  bit_y = w_xnor;
                OP_NOTA:  bit_y = w_not;
                OP_PASSB: bit_y = b[i];
                default:  bit_y = b[i];
            endcase
        end

        assign y[i] = bit_y;
    end

endmodule

// File: rtl/bitwise_unit_pipe.sv
// Registered bitwise unit with single-op and multi-beat fold modes; result one cycle after accept.
// Input is stalled (IN_READY low) only while a result is held and the consumer is not taking it.
module bitwise_unit_pipe
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [2:0]       OP,
    input  logic             ACC,
    input  logic             LAST,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             ZR,
    output logic             NG,
    output logic [CNT_W-1:0] BEATS
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] beats_q;
    logic [CNT_W-1:0] beats_d;
    logic             out_vld_q;
    logic             out_vld_d;
    logic             zr_q;
    logic             ng_q;
    logic             accept;
    logic             load_out;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic [WIDTH-1:0] core_y;
    op_e              op_sel;

    assign IN_READY = !out_vld_q || OUT_READY;
    assign accept   = IN_VALID && IN_READY;
    assign op_sel   = op_e'(OP);

    // One operator serves both modes: a fold combines the running value with the new beat.
    assign core_a = (state_q == ACCUM) ? acc_q : X;
    assign core_b = (state_q == ACCUM) ? X : Y;

    // Beat count sticks at all-ones instead of wrapping.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    bitwise_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op (op_sel),
        .a  (core_a),
        .b  (core_b),
        .y  (core_y)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        beats_d  = beats_q;
        load_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!ACC) begin
                        load_out = 1'b1;
                        out_d    = core_y;
                        beats_d  = CNT_W'(1);
                    end else if (LAST) begin
                        load_out = 1'b1;
                        out_d    = X;
                        beats_d  = CNT_W'(1);
                    end else begin
                        acc_d   = X;
                        cnt_d   = CNT_W'(1);
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (LAST) begin
                        load_out = 1'b1;
                        out_d    = core_y;
                        beats_d  = cnt_inc;
                        state_d  = IDLE;
                    end else begin
                        acc_d = core_y;
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        out_vld_d = out_vld_q;
        if (load_out) begin
            out_vld_d = 1'b1;
        end else if (OUT_READY) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            beats_q   <= '0;
            out_vld_q <= 1'b0;
            zr_q      <= 1'b1;
            ng_q      <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            beats_q   <= beats_d;
            out_vld_q <= out_vld_d;
            if (load_out) begin
                zr_q <= (out_d == '0);
                ng_q <= out_d[WIDTH-1];
            end
        end
    end

    assign OUT_VALID = out_vld_q;
    assign OUT       = out_q;
    assign ZR        = zr_q;
    assign NG        = ng_q;
    assign BEATS     = beats_q;

endmodule

// File: tb/tb_bitwise_unit_pipe.sv
// Bench for bitwise_unit_pipe: directed scenarios plus random traffic against a transaction-level model.
// A second instance with a 2-bit beat counter shares the stimulus to exercise saturation.
module tb_bitwise_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic [2:0]  op = '0;
    logic        acc = 1'b0;
    logic        last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_dat;
    logic        zr;
    logic        ng;
    logic [7:0]  beats;

    logic        in_ready_s;
    logic        out_valid_s;
    logic [15:0] out_dat_s;
    logic        zr_s;
    logic        ng_s;
    logic [1:0]  beats_s;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model state
    bit          m_vld;
    logic [15:0] m_out;
    int          m_beats;
    bit          m_inseq;
    logic [15:0] m_acc;
    int          m_cnt;

    always #5 clk = ~clk;

    bitwise_unit_pipe #(.WIDTH(16), .CNT_W(8)) u_dut (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .X(x), .Y(y), .OP(op), .ACC(acc), .LAST(last),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT(out_dat),
        .ZR(zr), .NG(ng), .BEATS(beats)
    );

    bitwise_unit_pipe #(.WIDTH(16), .CNT_W(2)) u_dut_sat (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready_s),
        .X(x), .Y(y), .OP(op), .ACC(acc), .LAST(last),
        .OUT_VALID(out_valid_s), .OUT_READY(out_ready), .OUT(out_dat_s),
        .ZR(zr_s), .NG(ng_s), .BEATS(beats_s)
    );

    function automatic logic [15:0] f(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return b;
        endcase
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_vld   = 1'b0;
        m_out   = '0;
        m_beats = 0;
        m_inseq = 1'b0;
        m_acc   = '0;
        m_cnt   = 0;
    endtask

    task automatic model_update();
        bit          loaded;
        logic [15:0] r;
        loaded = 1'b0;
        if (in_valid && (!m_vld || out_ready)) begin
            if (!m_inseq) begin
                if (!acc) begin
                    m_out = f(op, x, y); m_beats = 1; loaded = 1'b1;
                end else if (last) begin
                    m_out = x; m_beats = 1; loaded = 1'b1;
                end else begin
                    m_acc = x; m_cnt = 1; m_inseq = 1'b1;
                end
            end else begin
                r = f(op, m_acc, x);
                m_cnt++;
                if (last) begin
                    m_out = r; m_beats = m_cnt; m_inseq = 1'b0; loaded = 1'b1;
                end else begin
                    m_acc = r;
                end
            end
        end
        if (loaded) m_vld = 1'b1;
        else if (out_ready) m_vld = 1'b0;
    endtask

    task automatic compare();
        check("in_ready", 32'(in_ready), 32'(!m_vld || out_ready));
        check("out_valid", 32'(out_valid), 32'(m_vld));
        check("out", 32'(out_dat), 32'(m_out));
        check("zr", 32'(zr), 32'(m_out == 16'h0));
        check("ng", 32'(ng), 32'(m_out[15]));
        check("beats", 32'(beats), 32'(sat(m_beats, 255)));
        check("sat_out_valid", 32'(out_valid_s), 32'(m_vld));
        check("sat_out", 32'(out_dat_s), 32'(m_out));
        check("sat_beats", 32'(beats_s), 32'(sat(m_beats, 3)));
    endtask

    task automatic drive(input logic v, input logic [15:0] xv, input logic [15:0] yv,
                         input logic [2:0] o, input logic a, input logic l, input logic r);
        in_valid = v; x = xv; y = yv; op = o; acc = a; last = l; out_ready = r;
    endtask

    // Inputs are changed only at negedge, so the model sees the values the DUT sampled.
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        check("rst_zr", 32'(zr), 32'd1);
        #1 rst_n = 1'b1;
    endtask

    logic [15:0] sweep_exp [8];
    logic [15:0] held;

    initial begin
        sweep_exp = '{16'hAA00, 16'hFFAA, 16'h55AA, 16'h55FF, 16'h0055, 16'hAA55, 16'h5555, 16'hFF00};
        model_reset();
        @(negedge clk);
        compare();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_beats", 32'(beats), 32'd0);
        #2 rst_n = 1'b1;

        // Traffic, then reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b1);
            cycle();
        end
        pulse_reset();

        drive(1'b1, 16'hF0F0, 16'h0FF0, 3'd1, 1'b0, 1'b0, 1'b1);
        cycle();
        check("t1_out", 32'(out_dat), 32'h0000FFF0);
        check("t1_zr", 32'(zr), 32'd0);
        check("t1_ng", 32'(ng), 32'd1);
        check("t1_beats", 32'(beats), 32'd1);
        check("t1_valid", 32'(out_valid), 32'd1);

        for (int o = 0; o < 8; o++) begin
            drive(1'b1, 16'hAAAA, 16'hFF00, 3'(o), 1'b0, 1'b0, 1'b1);
            cycle();
            check($sformatf("sweep_op%0d", o), 32'(out_dat), 32'(sweep_exp[o]));
        end

        // Backpressure: result held, queued beat loads exactly once on release
        drive(1'b1, 16'h1234, 16'h00FF, 3'd0, 1'b0, 1'b0, 1'b1);
        cycle();
        held = out_dat;
        check("bp_first", 32'(held), 32'h00000034);
        drive(1'b1, 16'hABCD, 16'h0000, 3'd7, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold", 32'(out_dat), 32'(held));
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release", 32'(out_dat), 32'h00000000);
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        cycle();
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // OR fold of four beats
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(16'h0001 << (4 * i)), 16'hFFFF, 3'd1, 1'b1, 1'(i == 3), 1'b1);
            cycle();
            if (i < 3) check("fold_no_early", 32'(out_valid), 32'd0);
        end
        check("fold_out", 32'(out_dat), 32'h00001111);
        check("fold_beats", 32'(beats), 32'd4);

        // XOR to zero, then single-beat accumulate
        drive(1'b1, 16'h8001, 16'h0, 3'd2, 1'b1, 1'b0, 1'b1); cycle();
        drive(1'b1, 16'h8001, 16'h0, 3'd2, 1'b1, 1'b1, 1'b1); cycle();
        check("xor_zero_out", 32'(out_dat), 32'd0);
        check("xor_zero_zr", 32'(zr), 32'd1);
        check("xor_zero_ng", 32'(ng), 32'd0);
        drive(1'b1, 16'h8000, 16'h0, 3'd0, 1'b1, 1'b1, 1'b1); cycle();
        check("single_acc_out", 32'(out_dat), 32'h00008000);
        check("single_acc_ng", 32'(ng), 32'd1);

        // Reset after two of four beats; the following single op must be clean
        drive(1'b1, 16'h00F0, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1); cycle();
        drive(1'b1, 16'h0F00, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1); cycle();
        pulse_reset();
        drive(1'b1, 16'h0003, 16'h0005, 3'd1, 1'b1, 1'b1, 1'b1); cycle();
        check("post_rst_acc_single", 32'(out_dat), 32'h00000003);
        drive(1'b1, 16'h0003, 16'h0005, 3'd2, 1'b0, 1'b0, 1'b1); cycle();
        check("post_rst_single", 32'(out_dat), 32'h00000006);

        // Six-beat fold: 2-bit counter saturates at 3
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'(16'h0001 << i), 16'h0, 3'd1, 1'b1, 1'(i == 5), 1'b1);
            cycle();
        end
        check("sat_beats_cnt2", 32'(beats_s), 32'd3);
        check("sat_beats_cnt8", 32'(beats), 32'd6);
        check("sat_fold_out", 32'(out_dat_s), 32'h0000003F);

        // Random traffic with backpressure and mixed modes
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 3'($urandom),
                  1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 3),
                  1'($urandom_range(0, 9) < 7));
            cycle();
            if (i == 300) pulse_reset();
        end

        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
